// File: rtl/loopback_xform_buffer.sv
// loopback_xform_buffer: register-mapped fill/drain loopback buffer.
// Software pushes DEPTH words through DATA_IN (each transformed on entry by
// the CTRL mode and OPERAND), then pops them back from DATA_OUT.
module loopback_xform_buffer #(
    parameter int          DATA_W      = 16,
    parameter int          DEPTH       = 25,
    parameter int unsigned OFFSET_INIT = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic [2:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              done
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    localparam logic [2:0] A_CTRL = 3'd0;
    localparam logic [2:0] A_STAT = 3'd1;
    localparam logic [2:0] A_OPND = 3'd2;
    localparam logic [2:0] A_DIN  = 3'd3;
    localparam logic [2:0] A_DOUT = 3'd4;

    typedef enum logic { S_FILL, S_DRAIN } state_t;

    state_t            r_state;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_operand;
    logic              r_ovf;
    logic              r_udf;
    logic [CNT_W-1:0]  r_cnt;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic              r_done;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_mem [DEPTH];

    // A simultaneous read+write is treated as a write only.
    logic              w_wr;
    logic              w_rd;
    logic              w_push;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_xf;
    logic [DATA_W-1:0] w_status;

    assign w_wr   = chipselect & write;
    assign w_rd   = chipselect & read & ~write;
    assign w_push = w_wr && (address == A_DIN) && (r_state == S_FILL);
    assign w_sum  = {1'b0, writedata} + {1'b0, r_operand};

    // Entry transform, using the mode/operand currently held in the registers
    always_comb begin
        case (r_mode)
            2'd0:    w_xf = writedata;
            2'd1:    w_xf = w_sum[DATA_W-1:0];
            2'd2:    w_xf = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
            default: w_xf = writedata ^ r_operand;
        endcase
    end

    // STATUS word: done, overflow, underflow, occupancy count
    always_comb begin
        w_status              = '0;
        w_status[0]           = r_done;
        w_status[1]           = r_ovf;
        w_status[2]           = r_udf;
        w_status[CNT_W+2:3]   = r_cnt;
    end

    // Word storage; contents survive reset and soft clear
    always_ff @(posedge clk) begin
        if (reset && w_push)
            r_mem[r_wr_ptr] <= w_xf;
    end

    // Register file, fill/drain FSM and registered read data
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_FILL;
            r_mode    <= 2'd1;
            r_operand <= DATA_W'(OFFSET_INIT);
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
            r_cnt     <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_done    <= 1'b0;
            r_rdata   <= '0;
        end else if (w_wr) begin
            case (address)
                A_CTRL: begin
                    r_mode <= writedata[1:0];
                    if (writedata[2]) begin
                        r_state  <= S_FILL;
                        r_cnt    <= '0;
                        r_wr_ptr <= '0;
                        r_rd_ptr <= '0;
                        r_done   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_udf    <= 1'b0;
                    end
                end
                A_STAT: begin
                    if (writedata[1]) r_ovf <= 1'b0;
                    if (writedata[2]) r_udf <= 1'b0;
                end
                A_OPND: r_operand <= writedata;
                A_DIN: begin
                    if (r_state == S_FILL) begin
                        r_cnt    <= r_cnt + CNT_ONE;
                        r_wr_ptr <= r_wr_ptr + PTR_ONE;
                        if (r_cnt == CNT_LAST) begin
                            r_state  <= S_DRAIN;
                            r_done   <= 1'b1;
                            r_wr_ptr <= '0;
                        end
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (w_rd) begin
            case (address)
                A_CTRL: r_rdata <= DATA_W'(r_mode);
                A_STAT: r_rdata <= w_status;
                A_OPND: r_rdata <= r_operand;
                A_DOUT: begin
                    if (r_state == S_DRAIN) begin
                        r_rdata  <= r_mem[r_rd_ptr];
                        r_cnt    <= r_cnt - CNT_ONE;
                        r_rd_ptr <= r_rd_ptr + PTR_ONE;
                        if (r_cnt == CNT_ONE) begin
                            r_state  <= S_FILL;
                            r_done   <= 1'b0;
                            r_rd_ptr <= '0;
                            r_wr_ptr <= '0;
                        end
                    end else begin
                        r_rdata <= '0;
                        r_udf   <= 1'b1;
                    end
                end
                default: r_rdata <= '0;
            endcase
        end
    end

    assign readdata = r_rdata;
    assign done     = r_done;

endmodule

// File: tb/tb_loopback_xform_buffer.sv
// Randomised and directed bench for loopback_xform_buffer against a
// queue-based reference model; a second small instance covers DATA_W=32/DEPTH=4.
module tb_loopback_xform_buffer;
    localparam int DEPTH = 25;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs, rd, wr;
    logic [2:0]  addr;
    logic [15:0] wdata, rdata;
    logic        done;

    logic        b_cs, b_rd, b_wr;
    logic [2:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic        b_done;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int          m_mode;
    logic [15:0] m_op;
    logic [15:0] m_q [$];
    bit          m_drain, m_ovf, m_udf;

    always #5 clk = ~clk;

    loopback_xform_buffer dut (
        .clk(clk), .reset(rst_n), .chipselect(cs), .address(addr),
        .read(rd), .write(wr), .writedata(wdata), .readdata(rdata), .done(done)
    );

    loopback_xform_buffer #(.DATA_W(32), .DEPTH(4), .OFFSET_INIT(5)) dut32 (
        .clk(clk), .reset(rst_n), .chipselect(b_cs), .address(b_addr),
        .read(b_rd), .write(b_wr), .writedata(b_wdata), .readdata(b_rdata), .done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] xf(input int m, input logic [15:0] op, input logic [15:0] d);
        longint s;
        s = longint'(d) + longint'(op);
        case (m)
            0:       return d;
            1:       return 16'(s % 65536);
            2:       return (s > 65535) ? 16'hFFFF : 16'(s);
            default: return d ^ op;
        endcase
    endfunction

    // one bus cycle, driven and released on falling edges
    task automatic acc(input logic c, input logic r, input logic w,
                       input logic [2:0] a, input logic [15:0] d);
        cs = c; rd = r; wr = w; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    task automatic model_reset();
        m_mode = 1; m_op = 16'd5; m_q.delete();
        m_drain = 0; m_ovf = 0; m_udf = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic do_push(input logic [15:0] d);
        acc(1, 0, 1, 3'd3, d);
        if (m_drain) m_ovf = 1;
        else begin
            m_q.push_back(xf(m_mode, m_op, d));
            if (m_q.size() == DEPTH) m_drain = 1;
        end
    endtask

    task automatic do_pop(output logic [15:0] v);
        logic [15:0] exp;
        acc(1, 1, 0, 3'd4, 16'h0);
        v = rdata;
        if (m_drain) begin
            exp = m_q.pop_front();
            if (m_q.size() == 0) m_drain = 0;
        end else begin
            exp = 16'h0;
            m_udf = 1;
        end
        chk("pop", 32'(v), 32'(exp));
    endtask

    task automatic chk_status();
        int exp;
        acc(1, 1, 0, 3'd1, 16'h0);
        exp = (m_q.size() * 8) + (m_udf ? 4 : 0) + (m_ovf ? 2 : 0) + (m_drain ? 1 : 0);
        chk("status", 32'(rdata), 32'(exp));
        chk("done", 32'(done), 32'(m_drain));
    endtask

    task automatic do_ctrl(input logic [15:0] v);
        acc(1, 0, 1, 3'd0, v);
        m_mode = int'(v[1:0]);
        if (v[2]) begin
            m_q.delete(); m_drain = 0; m_ovf = 0; m_udf = 0;
        end
    endtask

    task automatic do_op(input logic [15:0] v);
        acc(1, 0, 1, 3'd2, v);
        m_op = v;
    endtask

    task automatic do_w1c(input logic [15:0] v);
        acc(1, 0, 1, 3'd1, v);
        if (v[1]) m_ovf = 0;
        if (v[2]) m_udf = 0;
    endtask

    task automatic chk_ctrl();
        acc(1, 1, 0, 3'd0, 16'h0);
        chk("ctrl", 32'(rdata), 32'(m_mode));
    endtask

    task automatic rand_burst();
        logic [15:0] v;
        for (int i = 0; i < DEPTH; i++) do_push(16'($urandom));
        chk_status();
        for (int i = 0; i < DEPTH; i++) do_pop(v);
        chk_status();
    endtask

    task automatic burst_first(input logic [1:0] mode, input logic [15:0] op,
                               input logic [15:0] d, input logic [15:0] exp);
        logic [15:0] v;
        do_ctrl({13'h0, 1'b1, mode});
        do_op(op);
        do_push(d);
        for (int i = 1; i < DEPTH; i++) do_push(16'($urandom));
        do_pop(v);
        chk("mode_first", 32'(v), 32'(exp));
        for (int i = 1; i < DEPTH; i++) do_pop(v);
    endtask

    task automatic b_acc(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
        b_cs = 1'b1; b_rd = r; b_wr = w; b_addr = a; b_wdata = d;
        @(posedge clk);
        @(negedge clk);
        b_cs = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
    endtask

    initial begin
        logic [15:0] v;
        int          op;
        rst_n = 1'b0;
        cs = 0; rd = 0; wr = 0; addr = 0; wdata = 0;
        b_cs = 0; b_rd = 0; b_wr = 0; b_addr = 0; b_wdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // reset state
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk_status();
        chk_ctrl();
        acc(1, 1, 0, 3'd2, 16'h0);
        chk("rst_operand", 32'(rdata), 32'd5);

        // default burst: add-5 loopback
        for (int i = 0; i < DEPTH; i++) do_push(16'(i));
        chk_status();
        for (int i = 0; i < DEPTH; i++) begin
            do_pop(v);
            chk("dflt", 32'(v), 32'(i + 5));
        end
        chk_status();

        // transform modes
        burst_first(2'd2, 16'hFFF0, 16'h0020, 16'hFFFF);
        burst_first(2'd1, 16'hFFF0, 16'h0020, 16'h0010);
        burst_first(2'd3, 16'h00FF, 16'h0F0F, 16'h0FF0);
        burst_first(2'd0, 16'h00FF, 16'h0F0F, 16'h0F0F);

        // error flags
        do_pop(v);
        chk_status();
        for (int i = 0; i < DEPTH; i++) do_push(16'($urandom));
        do_push(16'hBEEF);
        chk_status();
        do_pop(v);
        do_w1c(16'h0006);
        chk_status();
        for (int i = 1; i < DEPTH; i++) do_pop(v);
        chk_status();

        // soft clear mid-fill
        for (int i = 0; i < 10; i++) do_push(16'($urandom));
        do_ctrl(16'h0005);
        chk_status();
        chk_ctrl();
        rand_burst();

        // reset mid-drain
        for (int i = 0; i < DEPTH; i++) do_push(16'($urandom));
        for (int i = 0; i < 7; i++) do_pop(v);
        do_reset();
        chk("rstd_rdata", 32'(rdata), 32'h0);
        chk_status();
        chk_ctrl();
        for (int i = 0; i < DEPTH; i++) do_push(16'(i));
        for (int i = 0; i < DEPTH; i++) do_pop(v);
        chk_status();

        // read+write together: write wins, readdata holds; no-chipselect ignored
        acc(1, 1, 0, 3'd2, 16'h0);
        acc(1, 1, 1, 3'd3, 16'h1234);
        chk("rw_hold", 32'(rdata), 32'(m_op));
        m_q.push_back(xf(m_mode, m_op, 16'h1234));
        acc(0, 1, 1, 3'd3, 16'h5678);
        acc(0, 0, 1, 3'd0, 16'h0007);
        chk_status();
        acc(1, 1, 0, 3'd6, 16'h0);
        chk("reserved", 32'(rdata), 32'h0);

        // randomised traffic
        for (int n = 0; n < 500; n++) begin
            op = int'($urandom_range(0, 99));
            if (op < 42)       do_push(16'($urandom));
            else if (op < 80)  do_pop(v);
            else if (op < 88)  chk_status();
            else if (op < 91)  do_ctrl(16'($urandom_range(0, 3)) | (($urandom_range(0, 3) == 0) ? 16'h4 : 16'h0));
            else if (op < 95)  do_op(16'($urandom));
            else if (op < 98)  do_w1c(16'($urandom));
            else               chk_ctrl();
        end
        chk_status();

        // DATA_W=32, DEPTH=4 instance
        b_acc(0, 1, 3'd3, 32'hFFFF_FFFF);
        b_acc(0, 1, 3'd3, 32'd1);
        b_acc(0, 1, 3'd3, 32'd2);
        chk("w32_done_lo", 32'(b_done), 32'h0);
        b_acc(0, 1, 3'd3, 32'd3);
        chk("w32_done_hi", 32'(b_done), 32'h1);
        b_acc(1, 0, 3'd1, 32'h0);
        chk("w32_status", b_rdata, 32'h21);
        for (int i = 0; i < 4; i++) begin
            b_acc(1, 0, 3'd4, 32'h0);
            chk("w32_pop", b_rdata, (i == 0) ? 32'h4 : 32'(i + 5));
        end
        chk("w32_done_end", 32'(b_done), 32'h0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/loopback_xform_buffer.md
# loopback_xform_buffer

Parametrised, register-mapped loopback buffer used to exercise the HPS-to-FPGA lightweight bus path of the digit-recognition accelerator. Software streams DEPTH words into the block, each word is transformed on entry (pass, wrapping add, saturating add, or XOR with a programmable operand), and software then drains the transformed words back and compares them. Adds a control/status register file, sticky error flags and a soft clear on top of the earlier fixed-size add-5 loopback.

## Interface
- DATA_W, 16, data/register width; must satisfy DATA_W >= CNT_W+3
- DEPTH, 25, words per fill/drain burst (>= 2)
- OFFSET_INIT, 5, reset value of OPERAND register
- CNT_W (derived, not overridable), $clog2(DEPTH+1), occupancy counter width
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-low (asserted when 0, sampled on clk)
- chipselect  in  1  bus access qualifier
- address  in  3  register select
- read  in  1  read strobe (valid only with chipselect)
- write  in  1  write strobe (valid only with chipselect)
- writedata  in  DATA_W  write data
- readdata  out  DATA_W  registered read data
- done  out  1  high while buffer is full/draining (mirror of STATUS[0])

## Operation
- Register map (word addresses):
  - 0 CTRL R/W: [1:0] mode (0 pass, 1 wrapping add, 2 unsigned saturating add, 3 XOR); [2] soft clear, write-1 self-clearing, reads 0
  - 1 STATUS R: [0] done, [1] overflow, [2] underflow, [CNT_W+2:3] count; writing 1 to bit 1/2 clears that flag (W1C), other bits ignored
  - 2 OPERAND R/W, DATA_W bits
  - 3 DATA_IN W: push one word
  - 4 DATA_OUT R: pop one word
  - 5-7: reads return 0, writes ignored
- FSM states FILL and DRAIN; reset/soft clear -> FILL, pointers 0, count 0.
- FILL: write to DATA_IN stores f(writedata) at wr_ptr, wr_ptr++, count++. The write that makes count==DEPTH moves to DRAIN; done=1 the next cycle.
- f uses mode/OPERAND as registered at the write cycle; changes apply only to later words. Wrapping add is mod 2^DATA_W; saturating add clamps to all-ones.
- DRAIN: read of DATA_OUT returns mem[rd_ptr], rd_ptr++, count--. The read that makes count==0 moves to FILL; done=0 the next cycle; pointers reset to 0.
- Write to DATA_IN in DRAIN: ignored, overflow<=1. Read of DATA_OUT in FILL: readdata<=0, no pointer change, underflow<=1.
- Soft clear: resets FSM, pointers, count, done, both flags; mode bits written in the same access take effect; OPERAND untouched; memory contents not cleared.
- read and write both high in one access: write performed, read ignored, readdata holds.
- Accesses without chipselect have no effect.

## Timing
- Reset values: readdata 0, done 0, mode 1, OPERAND OFFSET_INIT, overflow 0, underflow 0, count 0, state FILL.
- Read latency 1: readdata valid the cycle after chipselect&read; holds until the next read.
- Register writes visible to a read issued the following cycle.
- Back-to-back pushes/pops every cycle supported; no wait states.
- STATUS read in the same cycle as a push/pop returns pre-update values.
- Reset asserted mid-fill or mid-drain: next cycle all state equals reset values.

## Test plan
- Defaults: after reset push 0..24 to DATA_IN -> done=1 after 25th, STATUS count=25; 25 pops return 5..29 in order; done=0 afterwards, count=0.
- Modes: OPERAND=0xFFF0, mode 2, push 0x0020 -> pop 0xFFFF; mode 1 same push -> 0x0010; mode 3 OPERAND=0x00FF push 0x0F0F -> 0x0FF0; mode 0 -> 0x0F0F.
- Errors: pop in FILL -> readdata 0, STATUS[2]=1; fill fully then push -> STATUS[1]=1, first pop unaffected; write 0b110 to STATUS -> flags 0.
- Soft clear mid-fill: push 10 words, write CTRL=0b101 -> count 0, done 0, mode 1; next 25 pushes/pops behave as fresh burst.
- Reset mid-drain: fill, pop 7, drive reset=0 one cycle -> all reset values; full burst repeats correctly.
- Parameter sweep DATA_W=32, DEPTH=4: 4 pushes set done, wrapping add of 0xFFFFFFFF+5 pops 0x00000004.
